// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_stage
// Purpose  : Registered RV32I opcode decoder with a valid/ready handshake.
//            Decodes the full instruction word into a 14-bit control bundle,
//            including optional M-extension and CSR classes and illegal
//            instruction detection. An accepted fence stalls further input
//            for FENCE_CYCLES cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   core clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   instruction present
//   in_ready   out  stage can accept
//   in_instr   in   32-bit instruction word
//   flush      in   discard held output and abort any fence drain
//   out_valid  out  control bundle valid
//   out_ready  in   downstream accepts
//   out_instr  out  registered copy of the accepted instruction
//   out_ctrl   out  [0]MemtoReg [1]RegWrite [2]MemWrite [3]MemRead
//                   [4]Branch [5]ALUSrc [6]Jump [7]Jalr [8]Lui [9]Auipc
//                   [10]Fence [11]MulDiv [12]Csr [13]Illegal
//   ill_count  out  saturating count of accepted Illegal instructions
// ============================================================================
module ctrl_decode_stage #(
    parameter int ENABLE_M     = 1,
    parameter int ENABLE_CSR   = 1,
    parameter int FENCE_CYCLES = 4,
    parameter int ILL_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [13:0]          out_ctrl,
    output logic [ILL_CNT_W-1:0] ill_count
);

    // Drain counter must hold FENCE_CYCLES; keep at least one bit.
    localparam int CNT_W = (FENCE_CYCLES > 1) ? $clog2(FENCE_CYCLES + 1) : 1;

    // Control bundle bit positions
    localparam int C_MEMTOREG = 0;
    localparam int C_REGWRITE = 1;
    localparam int C_MEMWRITE = 2;
    localparam int C_MEMREAD  = 3;
    localparam int C_BRANCH   = 4;
    localparam int C_ALUSRC   = 5;
    localparam int C_JUMP     = 6;
    localparam int C_JALR     = 7;
    localparam int C_LUI      = 8;
    localparam int C_AUIPC    = 9;
    localparam int C_FENCE    = 10;
    localparam int C_MULDIV   = 11;
    localparam int C_CSR      = 12;
    localparam int C_ILLEGAL  = 13;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 valid_q,  valid_d;
    logic [31:0]          instr_q,  instr_d;
    logic [13:0]          ctrl_q,   ctrl_d;
    logic [ILL_CNT_W-1:0] ill_q,    ill_d;

    logic [13:0]          dec;
    logic                 accept;

    wire  [6:0]           opcode = in_instr[6:0];
    wire  [2:0]           funct3 = in_instr[14:12];
    wire  [6:0]           funct7 = in_instr[31:25];

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_LOAD: begin
                dec[C_MEMTOREG] = 1'b1;
                dec[C_REGWRITE] = 1'b1;
                dec[C_MEMREAD]  = 1'b1;
                dec[C_ALUSRC]   = 1'b1;
            end
            OPC_STORE: begin
                dec[C_MEMWRITE] = 1'b1;
                dec[C_ALUSRC]   = 1'b1;
            end
            OPC_BRANCH: dec[C_BRANCH] = 1'b1;
            OPC_OPIMM: begin
                dec[C_REGWRITE] = 1'b1;
                dec[C_ALUSRC]   = 1'b1;
            end
            OPC_OP: begin
                dec[C_REGWRITE] = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_M != 0) dec[C_MULDIV]  = 1'b1;
                    else               dec[C_ILLEGAL] = 1'b1;
                end
            end
            OPC_LUI: begin
                dec[C_REGWRITE] = 1'b1;
                dec[C_ALUSRC]   = 1'b1;
                dec[C_LUI]      = 1'b1;
            end
            OPC_AUIPC: begin
                dec[C_REGWRITE] = 1'b1;
                dec[C_ALUSRC]   = 1'b1;
                dec[C_AUIPC]    = 1'b1;
            end
            OPC_JAL: begin
                dec[C_REGWRITE] = 1'b1;
                dec[C_JUMP]     = 1'b1;
            end
            OPC_JALR: begin
                dec[C_REGWRITE] = 1'b1;
                dec[C_ALUSRC]   = 1'b1;
                dec[C_JUMP]     = 1'b1;
                dec[C_JALR]     = 1'b1;
            end
            OPC_FENCE: dec[C_FENCE] = 1'b1;
            OPC_SYSTEM: begin
                // ecall/ebreak (funct3==0) pass through as a NOP
                if (ENABLE_CSR == 0) begin
                    dec[C_ILLEGAL] = 1'b1;
                end else if (funct3 != 3'b000) begin
                    dec[C_CSR]      = 1'b1;
                    dec[C_REGWRITE] = 1'b1;
                end
            end
            default: dec[C_ILLEGAL] = 1'b1;
        endcase
        // An illegal instruction must not trigger any side effect downstream
        if (dec[C_ILLEGAL]) begin
            dec[12:0] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;

        if (accept) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            ctrl_d  = dec;
            if (dec[C_ILLEGAL] && (ill_q != '1)) begin
                ill_d = ill_q + ILL_CNT_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // Counter holds the remaining stall cycles; leaving DRAIN on the
        // cycle after it reads 1 gives exactly FENCE_CYCLES stalled cycles.
        case (state_q)
            ST_RUN: begin
                if (accept && dec[C_FENCE] && (FENCE_CYCLES > 0)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(FENCE_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // Flush drops the held bundle and aborts the drain; in_ready is
        // already low so no accept happens this cycle.
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_RUN;
            cnt_d   = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ctrl_q  <= '0;
            ill_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_ctrl  = ctrl_q;
    assign ill_count = ill_q;

endmodule
`default_nettype wire
